// File: rtl/microwave_control.sv
// rtl/microwave_control.sv - microwave oven cook/pause/done sequencer with synchronized pushbuttons and door switch
module microwave_control #(
    parameter int unsigned DONE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       clearn,
    input  logic       startn,
    input  logic       stopn,
    input  logic       door_closed,
    input  logic       zero,
    input  logic       key_load,
    output logic       enable,
    output logic       load,
    output logic       timer_clearn,
    output logic       mag_on,
    output logic       alarm,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        COOK  = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t     cur_state, nxt_state;
    logic       start_s1, start_s2, start_d;
    logic       stop_s1, stop_s2, stop_d;
    logic       door_s1, door_s2;
    logic       start_p, stop_p;
    logic       clr_req;
    logic [7:0] done_cnt, done_cnt_nxt;

    // Buttons idle high in reset so release can never look like a falling edge.
    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            start_s1 <= 1'b1;
            start_s2 <= 1'b1;
            start_d  <= 1'b1;
            stop_s1  <= 1'b1;
            stop_s2  <= 1'b1;
            stop_d   <= 1'b1;
            door_s1  <= 1'b0;
            door_s2  <= 1'b0;
        end else begin
            start_s1 <= startn;
            start_s2 <= start_s1;
            start_d  <= start_s2;
            stop_s1  <= stopn;
            stop_s2  <= stop_s1;
            stop_d   <= stop_s2;
            door_s1  <= door_closed;
            door_s2  <= door_s1;
        end
    end

    assign start_p = start_d & ~start_s2;
    assign stop_p  = stop_d & ~stop_s2;

    always_comb begin
        nxt_state    = cur_state;
        done_cnt_nxt = done_cnt;
        clr_req      = 1'b0;
        case (cur_state)
            IDLE: begin
                if (start_p && !stop_p && door_s2 && !zero)
                    nxt_state = COOK;
            end
            COOK: begin
                if (zero) begin
                    nxt_state    = DONE;
                    done_cnt_nxt = 8'(DONE_CYCLES);
                end else if (!door_s2 || stop_p) begin
                    nxt_state = PAUSE;
                end
            end
            PAUSE: begin
                if (stop_p) begin
                    nxt_state = IDLE;
                    clr_req   = 1'b1;
                end else if (start_p && door_s2 && !zero) begin
                    nxt_state = COOK;
                end
            end
            DONE: begin
                if (start_p || stop_p || !door_s2 || done_cnt <= 8'd1) begin
                    nxt_state    = IDLE;
                    done_cnt_nxt = 8'd0;
                end else begin
                    done_cnt_nxt = done_cnt - 8'd1;
                end
            end
            default: begin
                nxt_state    = IDLE;
                done_cnt_nxt = 8'd0;
            end
        endcase
    end

    // Outputs follow the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            cur_state    <= IDLE;
            done_cnt     <= 8'd0;
            enable       <= 1'b0;
            alarm        <= 1'b0;
            load         <= 1'b0;
            timer_clearn <= 1'b1;
        end else begin
            cur_state    <= nxt_state;
            done_cnt     <= done_cnt_nxt;
            enable       <= (nxt_state == COOK);
            alarm        <= (nxt_state == DONE);
            load         <= key_load && (cur_state == IDLE || cur_state == PAUSE);
            timer_clearn <= ~clr_req;
        end
    end

    // Raw door input so opening the door cuts the magnetron without sync delay.
    assign mag_on = (cur_state == COOK) && door_closed;
    assign state  = cur_state;

endmodule
